// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
//   Shared types and constants for the multiply/divide sequencer.
//   - mdu_op_t    : 3-bit operation code driven by decode
//   - mdu_state_t : sequencer FSM states
//   - MDU_WIDTH   : default operand width
//   - is_signed_op: true for the ops whose operands are two's complement
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// ---------------------------------------------------------------------------
// mdu_sequencer_if
//   Datapath <-> multiply/divide unit connection.
//   master (datapath/decode): drives start, op, srca, srcb, hilo_rd;
//                             receives stall, busy, done, hi, lo.
//   slave  (mdu_sequencer)  : the mirror image.
//   start   : issue op this cycle
//   op      : mdu_op_t operation code
//   srca    : rs value (multiplicand / dividend / mthi-mtlo data)
//   srcb    : rt value (multiplier / divisor)
//   hilo_rd : decode holds mfhi/mflo this cycle
//   stall   : hold PC and block regwrite
//   busy    : long op in flight
//   done    : one-cycle pulse after HI/LO updated by a long op
//   hi, lo  : architectural HI/LO registers
// ---------------------------------------------------------------------------
interface mdu_sequencer_if #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
);
  import mdu_pkg::*;

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hilo_rd;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, hilo_rd,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, hilo_rd,
    output stall, busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_divstep.sv
// ---------------------------------------------------------------------------
// mdu_divstep
//   One combinational restoring-division step on unsigned magnitudes.
//   The partial remainder is shifted left taking in the next dividend bit
//   (MSB of quot_in); the divisor is trial-subtracted and the result kept
//   only when it does not borrow. The quotient bit enters at the LSB of
//   quot_out as the dividend bits leave at its MSB.
//   rem_in/quot_in  : current {remainder, dividend-shifting-into-quotient}
//   divisor         : unsigned divisor magnitude (nonzero)
//   rem_out/quot_out: values after this step
// ---------------------------------------------------------------------------
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    rem_sh = {rem_in, quot_in[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    // trial[WIDTH] set means the subtraction borrowed: restore.
    if (trial[WIDTH]) begin
      rem_out  = rem_sh[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out  = trial[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//   Iterative multiply/divide unit owning HI/LO (mult, multu, div, divu,
//   mthi, mtlo). Radix-2 shift-add multiply and restoring divide, one bit
//   per cycle, on unsigned magnitudes with a final sign-fix cycle.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; clears all state, aborts any op
//     bus   : mdu_sequencer_if.slave (start/op/srca/srcb/hilo_rd in,
//             stall/busy/done/hi/lo out)
//   Configuration:
//     MDU_EARLY_TERM_EN : when defined, a multiply leaves the MUL state as
//                         soon as the remaining multiplier bits are all
//                         zero (or skips MUL entirely for a zero
//                         multiplier). Results are unchanged; division is
//                         unaffected.
// ---------------------------------------------------------------------------
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mdu_sequencer_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Architectural and sequencing state
  mdu_state_t         state, state_n;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: product; div: {remainder, quotient}
  logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left each MUL cycle
  logic [WIDTH-1:0]   opb;      // multiplier (shifted right) or divisor
  logic               is_div;
  logic               neg_q;    // negate product / quotient in FIX
  logic               neg_r;    // negate remainder in FIX
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Issue-time operand conditioning
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_by_zero;

  // Per-cycle datapath results
  logic [WIDTH-1:0]   rem_nx, quot_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               mul_last;
  logic               mul_skip;

  // Only an idle unit takes a new op; anything issued while busy is
  // dropped here and reissued by decode once stall clears.
  assign accept = (state == ST_IDLE) && !busy_q && bus.start;

  always_comb begin
    a_neg = is_signed_op(bus.op) & bus.srca[WIDTH-1];
    b_neg = is_signed_op(bus.op) & bus.srcb[WIDTH-1];
    // Negating the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    a_mag = a_neg ? -bus.srca : bus.srca;
    b_mag = b_neg ? -bus.srcb : bus.srcb;
  end

  assign div_by_zero = (bus.srcb == '0);

`ifdef MDU_EARLY_TERM_EN
  // Bits above the one consumed this cycle are all zero: nothing left to add.
  assign mul_last = (cnt == LAST) || (opb[WIDTH-1:1] == '0);
  assign mul_skip = (b_mag == '0);
`else
  assign mul_last = (cnt == LAST);
  assign mul_skip = 1'b0;
`endif

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in   (acc[2*WIDTH-1:WIDTH]),
    .quot_in  (acc[WIDTH-1:0]),
    .divisor  (opb),
    .rem_out  (rem_nx),
    .quot_out (quot_nx)
  );

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch forms.
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU: state_n = mul_skip ? ST_FIX : ST_MUL;
            MDU_DIV, MDU_DIVU:   if (!div_by_zero) state_n = ST_DIV;
            default:             state_n = ST_IDLE;
          endcase
        end
      end
      ST_MUL:  if (mul_last)     state_n = ST_FIX;
      ST_DIV:  if (cnt == LAST)  state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath, HI/LO and status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_n != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.op)
              MDU_MTHI: hi_q <= bus.srca;
              MDU_MTLO: lo_q <= bus.srca;
              MDU_MULT, MDU_MULTU: begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                opb    <= b_mag;
                cnt    <= '0;
                is_div <= 1'b0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
              end
              MDU_DIV, MDU_DIVU: begin
                if (div_by_zero) begin
                  // Defined result instead of a trap; raw dividend to HI.
                  hi_q   <= bus.srca;
                  lo_q   <= '1;
                  done_q <= 1'b1;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  opb    <= b_mag;
                  cnt    <= '0;
                  is_div <= 1'b1;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                end
              end
              default: ;
            endcase
          end
        end

        ST_MUL: begin
          if (opb[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + CW'(1);
        end

        ST_DIV: begin
          acc <= {rem_nx, quot_nx};
          cnt <= cnt + CW'(1);
        end

        ST_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end

        default: ;
      endcase
    end
  end

  // Stall only when the datapath actually needs the unit or HI/LO.
  assign bus.stall = busy_q & (bus.start | bus.hilo_rd);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdu_sequencer
//   Directed self-checking bench for mdu_sequencer. Each scenario task
//   drives its vectors and compares against hand-computed values.
//   Expected multiply busy lengths follow MDU_EARLY_TERM_EN.
// ---------------------------------------------------------------------------
module tb_mdu_sequencer;
  import mdu_pkg::*;

`ifdef MDU_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mdu_sequencer_if #(.WIDTH(32)) bus ();

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Issue one op: start is high for exactly one rising edge (E0).
  // Returns at E0 + 1.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Issue a long op and follow it to completion. cyc = number of cycles
  // busy was high; done_end is sampled right after busy falls, done_next
  // one cycle later; hi/lo are captured when busy falls.
  task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic done_end, output logic done_next,
                        output logic [31:0] hi, output logic [31:0] lo);
    issue(op, a, b);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    done_end = bus.done;
    hi       = bus.hi;
    lo       = bus.lo;
    @(posedge clk);
    #1;
    done_next = bus.done;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = MDU_MULT;
    bus.srca    = '0;
    bus.srcb    = '0;
    bus.hilo_rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (bus.hi !== 32'h0)    begin miscompares++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    vectors++; if (bus.lo !== 32'h0)    begin miscompares++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    vectors++; if (bus.busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0)   begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.stall !== 1'b0)  begin miscompares++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
  endtask

  task automatic test_mthi_mtlo();
    issue(MDU_MTHI, 32'h0000_1234, 32'h0);
    bus.hilo_rd = 1'b1;
    #1;
    vectors++; if (bus.hi !== 32'h0000_1234) begin miscompares++; $display("FAIL mthi_hi: got %h want %h", bus.hi, 32'h1234); end
    vectors++; if (bus.stall !== 1'b0)       begin miscompares++; $display("FAIL mthi_stall: got %b want 0", bus.stall); end
    vectors++; if (bus.busy !== 1'b0)        begin miscompares++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0)        begin miscompares++; $display("FAIL mthi_done: got %b want 0", bus.done); end
    bus.hilo_rd = 1'b0;
    issue(MDU_MTLO, 32'h0000_5678, 32'h0);
    vectors++; if (bus.lo !== 32'h0000_5678) begin miscompares++; $display("FAIL mtlo_lo: got %h want %h", bus.lo, 32'h5678); end
    vectors++; if (bus.hi !== 32'h0000_1234) begin miscompares++; $display("FAIL mtlo_hi_kept: got %h want %h", bus.hi, 32'h1234); end
  endtask

  task automatic test_mult();
    int cyc; logic de, dn; logic [31:0] h, l;
    // -2 * 3 = -6
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, cyc, de, dn, h, l);
    vectors++; if (h !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h want %h", h, 32'hFFFF_FFFF); end
    vectors++; if (l !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo: got %h want %h", l, 32'hFFFF_FFFA); end
    vectors++; if (cyc != (EARLY ? 3 : 33)) begin miscompares++; $display("FAIL mult_cycles: got %0d want %0d", cyc, EARLY ? 3 : 33); end
    vectors++; if (de !== 1'b1) begin miscompares++; $display("FAIL mult_done: got %b want 1", de); end
    vectors++; if (dn !== 1'b0) begin miscompares++; $display("FAIL mult_done_pulse: got %b want 0", dn); end
  endtask

  task automatic test_multu();
    int cyc; logic de, dn; logic [31:0] h, l;
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, de, dn, h, l);
    vectors++; if (h !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi: got %h want %h", h, 32'hFFFF_FFFE); end
    vectors++; if (l !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo: got %h want %h", l, 32'h1); end
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL multu_cycles: got %0d want 33", cyc); end
  endtask

  task automatic test_div();
    int cyc; logic de, dn; logic [31:0] h, l;
    // -7 / 2 = -3 rem -1
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, cyc, de, dn, h, l);
    vectors++; if (l !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo: got %h want %h", l, 32'hFFFF_FFFD); end
    vectors++; if (h !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi: got %h want %h", h, 32'hFFFF_FFFF); end
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL div_cycles: got %0d want 33", cyc); end
    vectors++; if (de !== 1'b1) begin miscompares++; $display("FAIL div_done: got %b want 1", de); end
  endtask

  task automatic test_div_zero();
    issue(MDU_DIVU, 32'd100, 32'd0);
    vectors++; if (bus.hi !== 32'd100)      begin miscompares++; $display("FAIL divz_hi: got %h want %h", bus.hi, 32'd100); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divz_lo: got %h want %h", bus.lo, 32'hFFFF_FFFF); end
    vectors++; if (bus.busy !== 1'b0)       begin miscompares++; $display("FAIL divz_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b1)       begin miscompares++; $display("FAIL divz_done: got %b want 1", bus.done); end
    @(posedge clk);
    #1;
    vectors++; if (bus.done !== 1'b0)       begin miscompares++; $display("FAIL divz_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_overflow();
    int cyc; logic de, dn; logic [31:0] h, l;
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, de, dn, h, l);
    vectors++; if (l !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_lo: got %h want %h", l, 32'h8000_0000); end
    vectors++; if (h !== 32'h0000_0000) begin miscompares++; $display("FAIL ovf_hi: got %h want %h", h, 32'h0); end
  endtask

  task automatic test_stall();
    int cyc; int stall_bad;
    // 7 * -2^31 = 0xFFFF_FFFC_8000_0000; full-length even with early term.
    issue(MDU_MULT, 32'h0000_0007, 32'h8000_0000);
    repeat (4) begin @(posedge clk); #1; end
    bus.hilo_rd = 1'b1;
    bus.start   = 1'b1;
    bus.op      = MDU_MTHI;
    bus.srca    = 32'h0000_DEAD;
    #1;
    vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL stall_rd_busy: got %b want 1", bus.stall); end
    cyc = 4;
    stall_bad = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy === 1'b1 && bus.stall !== 1'b1) stall_bad++;
    end
    vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL stall_held: got %0d dropped cycles want 0", stall_bad); end
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL stall_cycles: got %0d want 33", cyc); end
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b want 0", bus.stall); end
    bus.start   = 1'b0;
    bus.hilo_rd = 1'b0;
    vectors++; if (bus.hi !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL stall_hi: got %h want %h", bus.hi, 32'hFFFF_FFFC); end
    vectors++; if (bus.lo !== 32'h8000_0000) begin miscompares++; $display("FAIL stall_lo: got %h want %h", bus.lo, 32'h8000_0000); end
    @(posedge clk);
    #1;
    vectors++; if (bus.hi !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL stall_ignored_op: got %h want %h", bus.hi, 32'hFFFF_FFFC); end
    bus.hilo_rd = 1'b1;
    #1;
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL stall_rd_idle: got %b want 0", bus.stall); end
    bus.hilo_rd = 1'b0;
  endtask

  task automatic test_early_term();
    int cyc; logic de, dn; logic [31:0] h, l;
    run_op(MDU_MULTU, 32'd5, 32'd3, cyc, de, dn, h, l);
    vectors++; if (h !== 32'd0)  begin miscompares++; $display("FAIL et_hi: got %h want 0", h); end
    vectors++; if (l !== 32'd15) begin miscompares++; $display("FAIL et_lo: got %h want %h", l, 32'd15); end
    vectors++; if (cyc != (EARLY ? 3 : 33)) begin miscompares++; $display("FAIL et_cycles: got %0d want %0d", cyc, EARLY ? 3 : 33); end
    // Zero multiplier: HI/LO were nonzero before, must clear.
    run_op(MDU_MULTU, 32'h0000_1234, 32'd0, cyc, de, dn, h, l);
    vectors++; if (h !== 32'd0 || l !== 32'd0) begin miscompares++; $display("FAIL et_zero_result: got %h_%h want 0_0", h, l); end
    vectors++; if (cyc != (EARLY ? 1 : 33)) begin miscompares++; $display("FAIL et_zero_cycles: got %0d want %0d", cyc, EARLY ? 1 : 33); end
    vectors++; if (de !== 1'b1) begin miscompares++; $display("FAIL et_zero_done: got %b want 1", de); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic de, dn; logic [31:0] h, l;
    run_op(MDU_DIVU, 32'd100, 32'd7, cyc, de, dn, h, l);
    vectors++; if (l !== 32'd14) begin miscompares++; $display("FAIL b2b_div_lo: got %h want %h", l, 32'd14); end
    vectors++; if (h !== 32'd2)  begin miscompares++; $display("FAIL b2b_div_hi: got %h want %h", h, 32'd2); end
    run_op(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, cyc, de, dn, h, l);
    vectors++; if (h !== 32'd1 || l !== 32'd0) begin miscompares++; $display("FAIL b2b_mul: got %h_%h want 00000001_00000000", h, l); end
    vectors++; if (cyc != (EARLY ? 18 : 33)) begin miscompares++; $display("FAIL b2b_mul_cycles: got %0d want %0d", cyc, EARLY ? 18 : 33); end
  endtask

  task automatic test_reset_mid_op();
    // HI/LO are nonzero from the previous scenario.
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (bus.hi !== 32'h0)  begin miscompares++; $display("FAIL rst_mid_hi: got %h want 0", bus.hi); end
    vectors++; if (bus.lo !== 32'h0)  begin miscompares++; $display("FAIL rst_mid_lo: got %h want 0", bus.lo); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_after: busy %b done %b want 0 0", bus.busy, bus.done); end
    vectors++; if (bus.lo !== 32'h0)  begin miscompares++; $display("FAIL rst_mid_no_write: got %h want 0", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_overflow();
    test_stall();
    test_early_term();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
